// File: rtl/gio_shiftout.sv
// rtl/gio_shiftout.sv - serializes a parallel output port into a 74HC595-style shift register
module gio_shiftout #(
    parameter int WIDTH     = 8,
    parameter int CLKDIV    = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pdata,
    input  logic             force_req,
    output logic             busy,
    output logic             sr_data,
    output logic             sr_clk,
    output logic             sr_latch
);

    localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic [WIDTH-1:0] shadow, shadow_nx;
    logic [BW-1:0]    bitcnt, bitcnt_nx;
    logic [DW-1:0]    divcnt, divcnt_nx;
    logic             init, init_nx;
    logic             pend, pend_nx;
    logic             busy_nx, sr_data_nx, sr_clk_nx, sr_latch_nx;
    logic             div_done;
    logic [WIDTH-1:0] shreg_adv;

    function automatic logic lead_bit(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    // The bit on the wire is always the leading end of shreg; advancing drops it.
    assign shreg_adv = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
    assign div_done  = (divcnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            shadow   <= '0;
            bitcnt   <= '0;
            divcnt   <= '0;
            init     <= 1'b1;
            pend     <= 1'b0;
            busy     <= 1'b0;
            sr_data  <= 1'b0;
            sr_clk   <= 1'b0;
            sr_latch <= 1'b0;
        end else begin
            state    <= state_nx;
            shreg    <= shreg_nx;
            shadow   <= shadow_nx;
            bitcnt   <= bitcnt_nx;
            divcnt   <= divcnt_nx;
            init     <= init_nx;
            pend     <= pend_nx;
            busy     <= busy_nx;
            sr_data  <= sr_data_nx;
            sr_clk   <= sr_clk_nx;
            sr_latch <= sr_latch_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        shreg_nx    = shreg;
        shadow_nx   = shadow;
        bitcnt_nx   = bitcnt;
        divcnt_nx   = divcnt;
        init_nx     = init;
        pend_nx     = pend;
        busy_nx     = busy;
        sr_data_nx  = sr_data;
        sr_clk_nx   = sr_clk;
        sr_latch_nx = sr_latch;

        case (state)
            IDLE: begin
                if (init || pend || force_req || (pdata != shadow)) begin
                    shreg_nx   = pdata;
                    shadow_nx  = pdata;
                    init_nx    = 1'b0;
                    pend_nx    = 1'b0;
                    busy_nx    = 1'b1;
                    bitcnt_nx  = BIT_LAST;
                    divcnt_nx  = '0;
                    sr_data_nx = lead_bit(pdata);
                    state_nx   = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (div_done) begin
                    divcnt_nx = '0;
                    sr_clk_nx = 1'b1;
                    state_nx  = SHIFT_HI;
                end else begin
                    divcnt_nx = divcnt + DW'(1);
                end
            end
            SHIFT_HI: begin
                if (div_done) begin
                    divcnt_nx = '0;
                    sr_clk_nx = 1'b0;
                    if (bitcnt == '0) begin
                        sr_latch_nx = 1'b1;
                        state_nx    = LATCH;
                    end else begin
                        bitcnt_nx  = bitcnt - BW'(1);
                        shreg_nx   = shreg_adv;
                        sr_data_nx = lead_bit(shreg_adv);
                        state_nx   = SHIFT_LO;
                    end
                end else begin
                    divcnt_nx = divcnt + DW'(1);
                end
            end
            LATCH: begin
                if (div_done) begin
                    divcnt_nx   = '0;
                    sr_latch_nx = 1'b0;
                    busy_nx     = 1'b0;
                    state_nx    = IDLE;
                end else begin
                    divcnt_nx = divcnt + DW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase

        // A resend requested mid-transfer is remembered and honoured once back in IDLE.
        if (state != IDLE && force_req) begin
            pend_nx = 1'b1;
        end
    end

endmodule

// File: tb/tb_gio_shiftout.sv
// tb/tb_gio_shiftout.sv - self-checking bench for gio_shiftout with a transfer-level reference model
module tb_gio_shiftout;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pdata;
    logic       frc;
    logic [2:0] busy, sd, sc, sl;

    always #5 clk = ~clk;

    gio_shiftout #(.WIDTH(8), .CLKDIV(2), .MSB_FIRST(1)) u0 (
        .clk(clk), .rst(rst), .pdata(pdata), .force_req(frc),
        .busy(busy[0]), .sr_data(sd[0]), .sr_clk(sc[0]), .sr_latch(sl[0]));
    gio_shiftout #(.WIDTH(8), .CLKDIV(2), .MSB_FIRST(0)) u1 (
        .clk(clk), .rst(rst), .pdata(pdata), .force_req(frc),
        .busy(busy[1]), .sr_data(sd[1]), .sr_clk(sc[1]), .sr_latch(sl[1]));
    gio_shiftout #(.WIDTH(8), .CLKDIV(1), .MSB_FIRST(1)) u2 (
        .clk(clk), .rst(rst), .pdata(pdata), .force_req(frc),
        .busy(busy[2]), .sr_data(sd[2]), .sr_clk(sc[2]), .sr_latch(sl[2]));

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] obs_q[3][$];
    logic [7:0] exp_q[3][$];
    int         blen[3];

    function automatic int cdiv(input int i);
        return (i == 2) ? 1 : 2;
    endfunction

    function automatic bit msbf(input int i);
        return (i != 1);
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = v[7-k];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) begin
            int n;
            chk($sformatf("sent_count[%0d]", i), obs_q[i].size(), exp_q[i].size());
            n = (obs_q[i].size() < exp_q[i].size()) ? obs_q[i].size() : exp_q[i].size();
            for (int j = 0; j < n; j++)
                chk($sformatf("sent_value[%0d][%0d]", i, j), obs_q[i][j], exp_q[i][j]);
            obs_q[i].delete();
            exp_q[i].delete();
        end
    endtask

    task automatic wait_busy();
        int k = 0;
        while (!busy[0] && k < 200) begin
            tick(1);
            k++;
        end
        chk("wait_busy", busy[0], 1'b1);
    endtask

    // Reference model: each transfer is a fixed-length busy window started from IDLE
    // whenever the start rule holds; it commits the value the 595 should show on completion.
    initial begin
        int         rem[3];
        logic [7:0] m_shadow[3], m_cur[3], sreg[3];
        bit         m_init[3], m_pend[3];
        bit         p_busy[3], p_sc[3], p_sl[3];
        int         bcnt[3], nrise[3], lw[3];
        for (int i = 0; i < 3; i++) begin
            rem[i] = 0; m_shadow[i] = 0; m_cur[i] = 0; sreg[i] = 0;
            m_init[i] = 1; m_pend[i] = 0;
            p_busy[i] = 0; p_sc[i] = 0; p_sl[i] = 0;
            bcnt[i] = 0; nrise[i] = 0; lw[i] = 0; blen[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (rst) begin
                    rem[i] = 0; m_shadow[i] = 0; m_init[i] = 1; m_pend[i] = 0;
                    chk($sformatf("reset_outputs[%0d]", i), {busy[i], sd[i], sc[i], sl[i]}, 4'b0);
                end
                chk($sformatf("busy[%0d]", i), busy[i], rem[i] > 0);
                if (rem[i] > 0) begin
                    if (frc) m_pend[i] = 1;
                    rem[i]--;
                    if (rem[i] == 0) exp_q[i].push_back(m_cur[i]);
                end else if (!rst && (m_init[i] || m_pend[i] || frc || pdata != m_shadow[i])) begin
                    m_cur[i]    = msbf(i) ? pdata : rev8(pdata);
                    m_shadow[i] = pdata;
                    m_init[i]   = 0;
                    m_pend[i]   = 0;
                    rem[i]      = 17 * cdiv(i);
                end

                if (busy[i] && !p_busy[i]) begin
                    bcnt[i]  = 0;
                    nrise[i] = 0;
                end
                if (sc[i] && !p_sc[i]) begin
                    chk($sformatf("rise_offset[%0d]", i), bcnt[i], cdiv(i) + 2 * cdiv(i) * nrise[i]);
                    sreg[i] = {sreg[i][6:0], sd[i]};
                    nrise[i]++;
                end
                if (sl[i] && !p_sl[i]) begin
                    chk($sformatf("latch_offset[%0d]", i), bcnt[i], 16 * cdiv(i));
                    chk($sformatf("rises_before_latch[%0d]", i), nrise[i], 8);
                    obs_q[i].push_back(sreg[i]);
                    lw[i] = 0;
                end
                if (sl[i]) lw[i]++;
                if (!sl[i] && p_sl[i] && !rst)
                    chk($sformatf("latch_width[%0d]", i), lw[i], cdiv(i));
                if (!busy[i] && p_busy[i] && !rst) blen[i] = bcnt[i];
                if (busy[i]) bcnt[i]++;
                chk($sformatf("clk_latch_exclusive[%0d]", i), sc[i] & sl[i], 1'b0);
                p_busy[i] = busy[i];
                p_sc[i]   = sc[i];
                p_sl[i]   = sl[i];
            end
        end
    end

    initial begin
        rst   = 1'b1;
        pdata = 8'h00;
        frc   = 1'b0;
        tick(3);
        chk("reset_busy", busy, 3'b000);
        rst = 1'b0;

        // init transfer of 0x00 after reset release
        tick(40);
        chk("init_count", obs_q[0].size(), 1);
        if (obs_q[0].size() > 0) chk("init_value", obs_q[0][0], 8'h00);
        chk("busy_len_div2", blen[0], 34);
        chk("busy_len_div1", blen[2], 17);
        drain();
        tick(20);
        chk("quiet_after_init", obs_q[0].size(), 0);
        drain();

        // 0x00 -> 0xAB in both bit orders
        pdata = 8'hAB;
        tick(40);
        if (obs_q[0].size() > 0) chk("ab_msb_first", obs_q[0][0], 8'hAB);
        if (obs_q[1].size() > 0) chk("ab_lsb_first", obs_q[1][0], 8'hD5);
        drain();

        // changes during a transfer coalesce into one follow-up
        pdata = 8'h00;
        tick(40);
        drain();
        pdata = 8'hAB;
        wait_busy();
        tick(5);
        pdata = 8'hAC;
        tick(7);
        pdata = 8'hAD;
        tick(100);
        chk("coalesce_count", obs_q[0].size(), 2);
        if (obs_q[0].size() == 2) begin
            chk("coalesce_first", obs_q[0][0], 8'hAB);
            chk("coalesce_last", obs_q[0][1], 8'hAD);
        end
        drain();

        // force resend in IDLE, then once more while busy
        pdata = 8'h5A;
        tick(40);
        drain();
        frc = 1'b1;
        tick(1);
        frc = 1'b0;
        tick(5);
        frc = 1'b1;
        tick(1);
        frc = 1'b0;
        tick(100);
        chk("force_count", obs_q[0].size(), 2);
        if (obs_q[0].size() == 2) begin
            chk("force_first", obs_q[0][0], 8'h5A);
            chk("force_second", obs_q[0][1], 8'h5A);
        end
        drain();

        // reset mid-transfer aborts without a latch; init transfer restores 0xFF
        pdata = 8'hFF;
        wait_busy();
        tick(20);
        rst = 1'b1;
        #1;
        chk("async_reset_drop", {busy[0], sd[0], sc[0], sl[0]}, 4'b0);
        tick(2);
        rst = 1'b0;
        tick(40);
        chk("post_reset_count", obs_q[0].size(), 1);
        if (obs_q[0].size() > 0) chk("post_reset_value", obs_q[0][0], 8'hFF);
        drain();

        // randomized value changes and force pulses
        for (int r = 0; r < 30; r++) begin
            pdata = 8'($urandom);
            frc   = ($urandom_range(0, 3) == 0);
            tick(1);
            frc = 1'b0;
            tick($urandom_range(1, 40));
        end
        tick(200);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
